div_sched: RTL and testbench

Divide scheduler for the RV32IM pipeline. It tracks every divide in flight in the fixed-latency pipelined divider, so back-to-back independent divides issue one per cycle with no blanket stall. It stalls the decode stage only on true hazards: RAW or WAW on a pending divide destination, or a register-file write-port collision. It also drives the divider's register-file write-back.

---
 rtl/div_sched.sv | 112 +++++++++++
 tb/tb_div_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Divide scheduler: tracks divides in flight in a fixed-latency pipelined divider,
// raises decode stalls on true hazards and drives the divider's register-file write-back.
module div_sched #(
    parameter int LAT       = 8,
    parameter int WB_OFFSET = 2,
    localparam int CW       = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_req_E,
    input  logic [4:0]    div_rd_E,
    input  logic          d_valid_D,
    input  logic [4:0]    rs1_D,
    input  logic [4:0]    rs2_D,
    input  logic          rs1_used_D,
    input  logic          rs2_used_D,
    input  logic          wr_D,
    input  logic          is_div_D,
    input  logic [4:0]    rd_D,
    output logic          stall_D,
    output logic          wb_div,
    output logic [4:0]    wb_rd,
    output logic [CW-1:0] inflight,
    output logic          busy
);

    // Slot k holds the divide that writes back k cycles from now.
    logic [LAT-1:0] slot_valid_reg;
    logic [LAT-1:0] slot_valid_next;
    logic [4:0]     slot_rd_reg  [LAT];
    logic [4:0]     slot_rd_next [LAT];
    logic [CW-1:0]  inflight_reg;
    logic [CW-1:0]  inflight_next;

    assign slot_valid_next[LAT-1] = div_req_E;
    assign slot_rd_next[LAT-1]    = div_rd_E;

    generate
        for (genvar gi = 0; gi < LAT - 1; gi++) begin : g_shift
            assign slot_valid_next[gi] = slot_valid_reg[gi+1];
            assign slot_rd_next[gi]    = slot_rd_reg[gi+1];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_rd_reg[gi]    <= 5'd0;
                end else begin
                    slot_valid_reg[gi] <= slot_valid_next[gi];
                    slot_rd_reg[gi]    <= slot_rd_next[gi];
                end
            end
        end
    endgenerate

    // The count is rebuilt from the slot contents every cycle, so it cannot drift.
    always_comb begin
        inflight_next = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight_next = inflight_next + {{(CW-1){1'b0}}, slot_valid_next[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign wb_div   = slot_valid_reg[0];
    assign wb_rd    = slot_rd_reg[0];
    assign inflight = inflight_reg;
    assign busy     = (inflight_reg != '0);

    logic raw_hit;
    logic waw_hit;
    logic struct_hit;

    // Slot 0 is skipped: its write lands in the same cycle the register file is read.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        if (div_req_E && (div_rd_E != 5'd0)) begin
            raw_hit = (rs1_used_D && (rs1_D == div_rd_E)) ||
                      (rs2_used_D && (rs2_D == div_rd_E));
            waw_hit = (rd_D == div_rd_E);
        end
        for (int k = 1; k < LAT; k++) begin
            if (slot_valid_reg[k] && (slot_rd_reg[k] != 5'd0)) begin
                if ((rs1_used_D && (rs1_D == slot_rd_reg[k])) ||
                    (rs2_used_D && (rs2_D == slot_rd_reg[k]))) begin
                    raw_hit = 1'b1;
                end
                if (rd_D == slot_rd_reg[k]) begin
                    waw_hit = 1'b1;
                end
            end
        end
    end

    // A non-divide writer entering E next cycle would share the write port with this slot.
    assign struct_hit = slot_valid_reg[WB_OFFSET+1];

    assign stall_D = d_valid_D &&
                     (raw_hit || (wr_D && !is_div_D && (waw_hit || struct_hit)));

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched; one line per checked transaction.
module tb_div_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_req_E;
    logic [4:0] div_rd_E;
    logic       d_valid_D;
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic       rs1_used_D;
    logic       rs2_used_D;
    logic       wr_D;
    logic       is_div_D;
    logic [4:0] rd_D;
    logic       stall_D;
    logic       wb_div;
    logic [4:0] wb_rd;
    logic [3:0] inflight;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    div_sched #(.LAT(8), .WB_OFFSET(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_req_E  (div_req_E),
        .div_rd_E   (div_rd_E),
        .d_valid_D  (d_valid_D),
        .rs1_D      (rs1_D),
        .rs2_D      (rs2_D),
        .rs1_used_D (rs1_used_D),
        .rs2_used_D (rs2_used_D),
        .wr_D       (wr_D),
        .is_div_D   (is_div_D),
        .rd_D       (rd_D),
        .stall_D    (stall_D),
        .wb_div     (wb_div),
        .wb_rd      (wb_rd),
        .inflight   (inflight),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        div_req_E  = 1'b0;
        div_rd_E   = 5'd0;
        d_valid_D  = 1'b0;
        rs1_D      = 5'd0;
        rs2_D      = 5'd0;
        rs1_used_D = 1'b0;
        rs2_used_D = 1'b0;
        wr_D       = 1'b0;
        is_div_D   = 1'b0;
        rd_D       = 5'd0;
    endtask

    // Leaves the bench 1 time unit after a posedge: cycle 0 of the next test.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_wb_div", wb_div, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_inflight", inflight, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_D, 0);
        $display("reset: wb_div=%0d inflight=%0d busy=%0d stall=%0d", wb_div, inflight, busy, stall_D);
        next_cycle();

        // Single divide to x5 at cycle 0
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd5; end
            @(negedge clk);
            check("single_wb_div", wb_div, (c == 8));
            if (c == 8) check("single_wb_rd", wb_rd, 5);
            check("single_inflight", inflight, (c >= 1 && c <= 8) ? 1 : 0);
            check("single_busy", busy, (c >= 1 && c <= 8));
            $display("single c=%0d wb_div=%0d wb_rd=%0d inflight=%0d busy=%0d", c, wb_div, wb_rd, inflight, busy);
            next_cycle();
        end

        // RAW: D reads x5 from cycle 0
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd5; end
            d_valid_D = 1'b1; rs1_D = 5'd5; rs1_used_D = 1'b1;
            @(negedge clk);
            check("raw_stall", stall_D, (c <= 7));
            $display("raw c=%0d stall=%0d", c, stall_D);
            next_cycle();
        end

        // Back-to-back independent divides x1..x8; D holds the next divide
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            idle();
            if (c <= 7) begin
                div_req_E = 1'b1; div_rd_E = 5'(c + 1);
                d_valid_D = 1'b1; is_div_D = 1'b1; wr_D = 1'b1; rd_D = 5'(c + 2);
                rs1_D = 5'd20; rs2_D = 5'd21; rs1_used_D = 1'b1; rs2_used_D = 1'b1;
            end
            @(negedge clk);
            exp_cnt = 0;
            for (int t = 0; t <= 7; t++) if (c >= t + 1 && c <= t + 8) exp_cnt++;
            check("b2b_stall", stall_D, 0);
            check("b2b_wb_div", wb_div, (c >= 8 && c <= 15));
            if (c >= 8 && c <= 15) check("b2b_wb_rd", wb_rd, c - 7);
            check("b2b_inflight", inflight, exp_cnt);
            $display("b2b c=%0d stall=%0d wb_div=%0d wb_rd=%0d inflight=%0d", c, stall_D, wb_div, wb_rd, inflight);
            next_cycle();
        end

        // Structural: divide x3 at cycle 0, ALU writer x9 in D at cycles 5 and 6
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd3; end
            if (c == 5 || c == 6) begin d_valid_D = 1'b1; wr_D = 1'b1; rd_D = 5'd9; end
            @(negedge clk);
            check("struct_stall", stall_D, (c == 5));
            if (c == 8) check("struct_wb_rd", wb_rd, 3);
            check("struct_wb_div", wb_div, (c == 8));
            $display("struct c=%0d stall=%0d wb_div=%0d", c, stall_D, wb_div);
            next_cycle();
        end

        // WAW: divide x6 at cycle 0, ALU writer x6 in D cycles 0..2
        do_reset();
        for (int c = 0; c <= 2; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd6; end
            d_valid_D = 1'b1; wr_D = 1'b1; rd_D = 5'd6;
            @(negedge clk);
            check("waw_stall", stall_D, 1);
            $display("waw c=%0d stall=%0d", c, stall_D);
            next_cycle();
        end

        // x0 divide: no RAW/WAW match, structural slot still occupied at cycle 5
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd0; end
            d_valid_D = 1'b1; rs1_used_D = 1'b1; rs2_used_D = 1'b1; wr_D = 1'b1; rd_D = 5'd0;
            @(negedge clk);
            check("x0_stall", stall_D, (c == 5));
            check("x0_wb_div", wb_div, (c == 8));
            if (c == 8) check("x0_wb_rd", wb_rd, 0);
            $display("x0 c=%0d stall=%0d wb_div=%0d wb_rd=%0d", c, stall_D, wb_div, wb_rd);
            next_cycle();
        end

        // Reset mid-flight: divide x7 at cycle 0, rst pulsed in cycle 4
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            idle();
            if (c == 0) begin div_req_E = 1'b1; div_rd_E = 5'd7; end
            d_valid_D = 1'b1; rs1_D = 5'd7; rs1_used_D = 1'b1;
            if (c == 4) begin
                #1 rst = 1'b1;
                #1;
                check("midrst_inflight", inflight, 0);
                check("midrst_busy", busy, 0);
                check("midrst_wb_div", wb_div, 0);
                check("midrst_stall", stall_D, 0);
                rst = 1'b0;
            end
            @(negedge clk);
            check("midrst_c_stall", stall_D, (c <= 3));
            check("midrst_c_wb_div", wb_div, 0);
            $display("midrst c=%0d stall=%0d wb_div=%0d inflight=%0d", c, stall_D, wb_div, inflight);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
